// File: rtl/cubic_stream_source.sv
// rtl/cubic_stream_source.sv - FIFO-backed AXI-Stream frame source for the horner cubic pipeline
// Host pushes words into a FIFO; on start, exactly frame_len beats are streamed with TLAST on the last.
module cubic_stream_source #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 16,
   parameter int LEN_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       wr_full,
   output logic                       wr_overflow,
   output logic [$clog2(DEPTH):0]     fifo_level,
   input  logic                       start,
   input  logic [LEN_W-1:0]           frame_len,
   output logic                       busy,
   output logic                       done,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic [DATA_W-1:0]          m_tdata,
   output logic                       m_tlast
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [LEN_W-1:0] ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
   logic [AW:0]         r_count;
   logic                r_overflow;
   logic [LEN_W-1:0]    r_len, r_loaded, r_beat_cnt;
   logic                r_tvalid, r_tlast;
   logic [DATA_W-1:0]   r_tdata;

   logic w_full, w_empty, w_push, w_pop, w_hs, w_start_ok, w_last_hs;

   assign w_full     = (r_count == (AW+1)'(DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_push     = wr_en && !w_full;
   assign w_hs       = r_tvalid && m_tready;
   // Refill the output register when it is empty or being drained this cycle.
   assign w_pop      = (r_state == S_RUN) && !w_empty && (r_loaded < r_len) && (!r_tvalid || w_hs);
   assign w_start_ok = (r_state == S_IDLE) && start && (frame_len != '0);
   assign w_last_hs  = w_hs && (r_beat_cnt == r_len - ONE);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
         S_RUN:   if (w_last_hs)  w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
         if (wr_en && w_full) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_len      <= '0;
         r_loaded   <= '0;
         r_beat_cnt <= '0;
         r_tvalid   <= 1'b0;
         r_tlast    <= 1'b0;
         r_tdata    <= '0;
      end else begin
         if (w_start_ok) begin
            r_len      <= frame_len;
            r_loaded   <= '0;
            r_beat_cnt <= '0;
         end else begin
            if (w_pop) r_loaded   <= r_loaded + ONE;
            if (w_hs)  r_beat_cnt <= r_beat_cnt + ONE;
         end
         if (w_pop) begin
            r_tvalid <= 1'b1;
            r_tdata  <= r_mem[r_rd_ptr];
            r_tlast  <= (r_loaded == r_len - ONE);
         end else if (w_hs) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
         end
      end
   end

   assign wr_full     = w_full;
   assign wr_overflow = r_overflow;
   assign fifo_level  = r_count;
   assign busy        = (r_state == S_RUN);
   assign done        = (r_state == S_DONE);
   assign m_tvalid    = r_tvalid;
   assign m_tdata     = r_tdata;
   assign m_tlast     = r_tlast;

endmodule

// File: tb/tb_cubic_stream_source.sv
// tb/tb_cubic_stream_source.sv - directed self-checking bench for cubic_stream_source
module tb_cubic_stream_source;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [63:0] wr_data = '0;
   logic        wr_full, wr_overflow;
   logic [4:0]  fifo_level;
   logic        start = 1'b0;
   logic [15:0] frame_len = '0;
   logic        busy, done, m_tvalid, m_tlast;
   logic        m_tready = 1'b0;
   logic [63:0] m_tdata;

   int total = 0;
   int bad   = 0;

   cubic_stream_source #(.DATA_W(64), .DEPTH(16), .LEN_W(16)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .wr_overflow(wr_overflow),
      .fifo_level(fifo_level),
      .start(start), .frame_len(frame_len), .busy(busy), .done(done),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] d);
      wr_en = 1'b1;
      wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic start_frame(input logic [15:0] len);
      start = 1'b1;
      frame_len = len;
      tick();
      start = 1'b0;
   endtask

   task automatic beat(input string tag, input logic [63:0] d, input logic last);
      chk({tag, " tvalid"}, {63'd0, m_tvalid}, 64'd1);
      chk({tag, " tdata"}, m_tdata, d);
      chk({tag, " tlast"}, {63'd0, m_tlast}, {63'd0, last});
   endtask

   task automatic idle_out(input string tag);
      chk({tag, " tvalid"}, {63'd0, m_tvalid}, 64'd0);
      chk({tag, " tdata"}, m_tdata, 64'd0);
      chk({tag, " tlast"}, {63'd0, m_tlast}, 64'd0);
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      idle_out("reset");
      chk("reset busy", {63'd0, busy}, 64'd0);
      chk("reset done", {63'd0, done}, 64'd0);
      chk("reset level", {59'd0, fifo_level}, 64'd0);
      chk("reset full", {63'd0, wr_full}, 64'd0);

      // 1: three beats back to back
      m_tready = 1'b1;
      push($realtobits(1.0));
      push($realtobits(2.0));
      push($realtobits(3.0));
      chk("t1 level", {59'd0, fifo_level}, 64'd3);
      start_frame(16'd3);
      chk("t1 busy", {63'd0, busy}, 64'd1);
      idle_out("t1 latency");
      tick();
      beat("t1 b1", $realtobits(1.0), 1'b0);
      tick();
      beat("t1 b2", $realtobits(2.0), 1'b0);
      tick();
      beat("t1 b3", $realtobits(3.0), 1'b1);
      tick();
      chk("t1 done", {63'd0, done}, 64'd1);
      idle_out("t1 after");
      chk("t1 level end", {59'd0, fifo_level}, 64'd0);
      tick();
      chk("t1 done pulse", {63'd0, done}, 64'd0);
      chk("t1 idle busy", {63'd0, busy}, 64'd0);

      // 2: backpressure on beat 2
      push($realtobits(1.0));
      push($realtobits(2.0));
      push($realtobits(3.0));
      start_frame(16'd3);
      tick();
      beat("t2 b1", $realtobits(1.0), 1'b0);
      tick();
      m_tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         beat("t2 hold", $realtobits(2.0), 1'b0);
         tick();
      end
      beat("t2 hold end", $realtobits(2.0), 1'b0);
      m_tready = 1'b1;
      tick();
      beat("t2 b3", $realtobits(3.0), 1'b1);
      tick();
      chk("t2 done", {63'd0, done}, 64'd1);
      chk("t2 level", {59'd0, fifo_level}, 64'd0);
      tick();

      // 3: fill to full, overflow, stream all 16
      for (int i = 0; i < 16; i++) push(64'd100 + 64'(i));
      chk("t3 full", {63'd0, wr_full}, 64'd1);
      chk("t3 ovf before", {63'd0, wr_overflow}, 64'd0);
      push(64'hDEAD);
      chk("t3 ovf", {63'd0, wr_overflow}, 64'd1);
      chk("t3 level", {59'd0, fifo_level}, 64'd16);
      start_frame(16'd16);
      tick();
      for (int i = 0; i < 16; i++) begin
         beat("t3 beat", 64'd100 + 64'(i), (i == 15));
         tick();
      end
      chk("t3 done", {63'd0, done}, 64'd1);
      chk("t3 level end", {59'd0, fifo_level}, 64'd0);
      chk("t3 ovf sticky", {63'd0, wr_overflow}, 64'd1);
      tick();

      // 4: underrun mid-frame
      push(64'd21);
      push(64'd22);
      start_frame(16'd4);
      tick();
      beat("t4 b1", 64'd21, 1'b0);
      tick();
      beat("t4 b2", 64'd22, 1'b0);
      tick();
      idle_out("t4 underrun");
      chk("t4 busy", {63'd0, busy}, 64'd1);
      tick();
      idle_out("t4 underrun2");
      push(64'd23);
      idle_out("t4 refill");
      push(64'd24);
      beat("t4 b3", 64'd23, 1'b0);
      tick();
      beat("t4 b4", 64'd24, 1'b1);
      tick();
      chk("t4 done", {63'd0, done}, 64'd1);
      tick();

      // 5: surplus words stay queued for the next frame
      for (int i = 0; i < 5; i++) push(64'd31 + 64'(i));
      start_frame(16'd2);
      tick();
      beat("t5 b1", 64'd31, 1'b0);
      tick();
      beat("t5 b2", 64'd32, 1'b1);
      chk("t5 level mid", {59'd0, fifo_level}, 64'd3);
      tick();
      chk("t5 done", {63'd0, done}, 64'd1);
      chk("t5 level", {59'd0, fifo_level}, 64'd3);
      tick();
      start_frame(16'd3);
      tick();
      beat("t5 c1", 64'd33, 1'b0);
      tick();
      beat("t5 c2", 64'd34, 1'b0);
      tick();
      beat("t5 c3", 64'd35, 1'b1);
      tick();
      chk("t5 done2", {63'd0, done}, 64'd1);
      chk("t5 level end", {59'd0, fifo_level}, 64'd0);
      tick();

      // 6: reset mid-frame under backpressure, then zero-length start
      push(64'd41);
      push(64'd42);
      m_tready = 1'b0;
      start_frame(16'd2);
      tick();
      beat("t6 pending", 64'd41, 1'b0);
      rst = 1'b1;
      tick();
      idle_out("t6 rst");
      chk("t6 busy", {63'd0, busy}, 64'd0);
      chk("t6 done", {63'd0, done}, 64'd0);
      chk("t6 level", {59'd0, fifo_level}, 64'd0);
      chk("t6 ovf", {63'd0, wr_overflow}, 64'd0);
      rst = 1'b0;
      m_tready = 1'b1;
      tick();
      chk("t6 no done", {63'd0, done}, 64'd0);
      start_frame(16'd0);
      chk("t6 len0 busy", {63'd0, busy}, 64'd0);
      tick();
      chk("t6 len0 busy2", {63'd0, busy}, 64'd0);
      idle_out("t6 len0");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
